uart_loader_ctrl: RTL and testbench

UART_LOADER_CTRL -- requirements
Module: uart_loader_ctrl

---
 rtl/uart_loader_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_loader_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader_ctrl.sv
// UART command loader: decodes single-byte commands from a UART receiver,
// controls CPU run/step/reset, and streams little-endian 32-bit words into
// instruction memory for the 'L' (load) command.
module uart_loader_ctrl #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 300000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              cpu_step,
    output logic              cpu_rst,
    output logic              busy,
    output logic              err,
    output logic [1:0]        state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_HALT  = 8'h48;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_CPURST = 8'h43;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            fsm;
    logic [7:0]        words_left;
    logic [1:0]        byte_idx;
    logic [23:0]       hold;
    logic [ADDR_W-1:0] wr_addr;
    logic [TW-1:0]     tmo_cnt;

    logic              tmo_hit;

    assign state   = fsm;
    // Inter-byte idle limit is reached on the edge where the count would hit TIMEOUT_CYCLES.
    assign tmo_hit = !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Command decoder, load sequencer and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm        <= S_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_run    <= 1'b0;
            cpu_step   <= 1'b0;
            cpu_rst    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            words_left <= '0;
            byte_idx   <= '0;
            hold       <= '0;
            wr_addr    <= '0;
            tmo_cnt    <= '0;
        end else begin
            imem_we  <= 1'b0;
            cpu_step <= 1'b0;
            cpu_rst  <= 1'b0;

            case (fsm)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_RUN: begin
                                cpu_run <= 1'b1;
                                err     <= 1'b0;
                            end
                            CMD_HALT: begin
                                cpu_run <= 1'b0;
                                err     <= 1'b0;
                            end
                            CMD_STEP: begin
                                if (!cpu_run) begin
                                    cpu_step <= 1'b1;
                                    err      <= 1'b0;
                                end
                            end
                            CMD_CPURST: begin
                                cpu_rst <= 1'b1;
                                cpu_run <= 1'b0;
                                err     <= 1'b0;
                            end
                            CMD_LOAD: begin
                                if (cpu_run) begin
                                    err <= 1'b1;
                                end else begin
                                    err  <= 1'b0;
                                    fsm  <= S_LEN;
                                    busy <= 1'b1;
                                end
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end

                S_LEN: begin
                    if (rx_valid) begin
                        tmo_cnt <= '0;
                        if (rx_data == 8'h00) begin
                            err  <= 1'b1;
                            fsm  <= S_IDLE;
                            busy <= 1'b0;
                        end else begin
                            words_left <= rx_data;
                            wr_addr    <= '0;
                            byte_idx   <= '0;
                            fsm        <= S_DATA;
                        end
                    end else if (tmo_hit) begin
                        err     <= 1'b1;
                        fsm     <= S_IDLE;
                        busy    <= 1'b0;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (rx_valid) begin
                        tmo_cnt  <= '0;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: hold[7:0]   <= rx_data;
                            2'd1: hold[15:8]  <= rx_data;
                            2'd2: hold[23:16] <= rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_data, hold};
                                imem_addr  <= wr_addr;
                                wr_addr    <= wr_addr + 1'b1;
                                if (words_left == 8'd1) begin
                                    fsm  <= S_IDLE;
                                    busy <= 1'b0;
                                end else begin
                                    words_left <= words_left - 8'd1;
                                end
                            end
                        endcase
                    end else if (tmo_hit) begin
                        // Partially assembled bytes in hold are simply abandoned.
                        err     <= 1'b1;
                        fsm     <= S_IDLE;
                        busy    <= 1'b0;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                default: begin
                    fsm  <= S_IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Bench for uart_loader_ctrl: command table plus load/timeout/reset sequences,
// with instruction-memory writes checked against a scoreboard queue.
module tb_uart_loader_ctrl;

    localparam int AW  = 8;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_run, cpu_step, cpu_rst, busy, err;
    logic [1:0]    state;

    uart_loader_ctrl #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_run(cpu_run), .cpu_step(cpu_step), .cpu_rst(cpu_rst),
        .busy(busy), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int step_cnt = 0;
    int rst_cnt = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t sb[$];

    logic [7:0] txq[$];

    typedef struct {
        logic [7:0] b;
        logic       run;
        logic       e;
        logic [1:0] st;
        logic       step;
        logic       rst;
    } vec_t;
    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every imem_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_step) step_cnt++;
            if (cpu_rst) rst_cnt++;
            if (imem_we) begin
                we_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_we: addr %h data %h with nothing expected", imem_addr, imem_wdata);
                end else begin
                    wr_t w;
                    w = sb.pop_front();
                    chk("we_addr", 32'(imem_addr), 32'(w.addr));
                    chk("we_data", imem_wdata, w.data);
                end
            end
        end
    end

    task automatic send_all();
        while (txq.size() > 0) begin
            rx_data  = txq.pop_front();
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        txq.push_back(b);
        send_all();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vt[0]  = '{8'h52, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        vt[1]  = '{8'h53, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        vt[2]  = '{8'h48, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vt[3]  = '{8'h53, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
        vt[4]  = '{8'h7F, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        vt[5]  = '{8'h48, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vt[6]  = '{8'h52, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        vt[7]  = '{8'h4C, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
        vt[8]  = '{8'h53, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
        vt[9]  = '{8'h43, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
        vt[10] = '{8'h4C, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        vt[11] = '{8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
        vt[12] = '{8'h4C, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        vt[13] = '{8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        reset = 1'b0;

        chk("rst_state", 32'(state), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_run_step_rst", {29'd0, cpu_run, cpu_step, cpu_rst}, 32'd0);
        chk("rst_busy_err", {30'd0, busy, err}, 32'd0);

        // Single-byte commands from IDLE, checked one cycle after each byte.
        for (int i = 0; i < 14; i++) begin
            send1(vt[i].b);
            chk($sformatf("vec%0d_run", i), 32'(cpu_run), 32'(vt[i].run));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].e));
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].st));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].st != 2'd0));
            chk($sformatf("vec%0d_step", i), 32'(cpu_step), 32'(vt[i].step));
            chk($sformatf("vec%0d_cpurst", i), 32'(cpu_rst), 32'(vt[i].rst));
        end
        idle(1);
        chk("step_pulse_count", 32'(step_cnt), 32'd1);
        chk("rst_pulse_count", 32'(rst_cnt), 32'd1);

        // Two-word load, fully back-to-back (byte lands during the first write pulse).
        sb.push_back('{8'd0, 32'h12345678});
        sb.push_back('{8'd1, 32'hDEADBEEF});
        txq = '{8'h4C, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_all();
        chk("load2_state_after_last", 32'(state), 32'd0);
        chk("load2_err", 32'(err), 32'd0);
        idle(2);
        chk("load2_busy", 32'(busy), 32'd0);
        chk("load2_sb_empty", 32'(sb.size()), 32'd0);
        chk("load2_we_count", 32'(we_cnt), 32'd2);

        // Command-valued bytes inside a load are data, not commands.
        sb.push_back('{8'd0, 32'h5348524C});
        txq = '{8'h4C, 8'h01, 8'h4C, 8'h52, 8'h48, 8'h53};
        send_all();
        idle(2);
        chk("cmd_as_data_sb_empty", 32'(sb.size()), 32'd0);
        chk("cmd_as_data_run", 32'(cpu_run), 32'd0);
        chk("cmd_as_data_steps", 32'(step_cnt), 32'd1);

        // Inter-byte timeout mid-word: one cycle short stays busy, then aborts.
        we_cnt = 0;
        txq = '{8'h4C, 8'h01, 8'hAA, 8'hBB};
        send_all();
        idle(TMO - 1);
        chk("tmo_pre_state", 32'(state), 32'd2);
        chk("tmo_pre_err", 32'(err), 32'd0);
        idle(1);
        chk("tmo_state", 32'(state), 32'd0);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        idle(3);
        chk("tmo_no_we", 32'(we_cnt), 32'd0);
        send1(8'h48);
        chk("tmo_clear_err", 32'(err), 32'd0);

        // Reset asserted after the 5th of 8 back-to-back bytes aborts the load.
        send1(8'h7F);
        txq = '{8'h4C, 8'h01, 8'h11, 8'h22, 8'h33};
        send_all();
        rx_valid = 1'b1;
        reset    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'h44 + 8'(i);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        reset    = 1'b0;
        idle(3);
        chk("rstmid_no_we", 32'(we_cnt), 32'd0);
        chk("rstmid_state", 32'(state), 32'd0);
        chk("rstmid_addr", 32'(imem_addr), 32'd0);
        chk("rstmid_wdata", imem_wdata, 32'd0);
        chk("rstmid_flags", {26'd0, imem_we, cpu_run, cpu_step, cpu_rst, busy, err}, 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
